// File: rtl/freq_meter.sv
// freq_meter
// ----------
// Gated frequency meter. Counts rising edges of an asynchronous input over a
// fixed window of GATE_CYCLES reference clocks and publishes the result with
// a one-cycle valid strobe. It is used to read back PLL-derived toggle
// signals as a number.
//
// Parameters
//   GATE_CYCLES : window length in i_clock cycles (>= 2)
//   COUNT_W     : width of the edge counter and of o_count
//
// Ports
//   i_clock    : reference clock
//   i_reset_n  : asynchronous active-low reset
//   i_enable   : synchronous enable; low holds both counters at zero
//   i_sig      : asynchronous signal under measurement
//   o_count    : edge count of the last completed window (saturating)
//   o_valid    : one-cycle strobe marking a new o_count
//   o_overflow : the last completed window saturated

module freq_meter #(
  parameter int GATE_CYCLES = 12_000_000,
  parameter int COUNT_W     = 32
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_sig,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_valid,
  output logic               o_overflow
);

  localparam int G_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [G_W-1:0]     G_LAST = G_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] E_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    CLOSE = 2'd2
  } state_t;

  state_t             state;
  logic               s1;
  logic               s2;
  logic               s3;
  logic               rise;
  logic [G_W-1:0]     g;
  logic [G_W-1:0]     g_inc;
  logic [COUNT_W-1:0] e;
  logic [COUNT_W:0]   e_sum;
  logic               e_carry;
  logic               sat_hit;

  // Three-flop chain: s1 only feeds s2 so it can settle from metastability;
  // a rising edge is seen as s2 high while s3 is still low.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_sig;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // One extra bit catches the case where the count would pass the maximum.
  assign e_sum   = {1'b0, e} + {{COUNT_W{1'b0}}, rise};
  assign e_carry = e_sum[COUNT_W];
  assign g_inc   = g + G_W'(1);

  // Window sequencer. CLOSE is entered exactly when g reaches its last value,
  // so the state register marks the terminal cycle without a wide compare in
  // the publish path. sat_hit remembers that the counter had to clip earlier
  // in the window, so overflow is reported even if no edge lands on the
  // terminal cycle itself.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      g          <= '0;
      e          <= '0;
      sat_hit    <= 1'b0;
      o_count    <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else if (!i_enable) begin
      state   <= IDLE;
      g       <= '0;
      e       <= '0;
      sat_hit <= 1'b0;
      o_valid <= 1'b0;
    end else if (state == CLOSE) begin
      // An edge detected in the terminal cycle still belongs to this window.
      state      <= COUNT;
      g          <= '0;
      e          <= '0;
      sat_hit    <= 1'b0;
      o_valid    <= 1'b1;
      o_count    <= e_carry ? E_MAX : e_sum[COUNT_W-1:0];
      o_overflow <= sat_hit | e_carry;
    end else begin
      // IDLE with enable high behaves as window cycle g = 0.
      state   <= (g_inc == G_LAST) ? CLOSE : COUNT;
      g       <= g_inc;
      o_valid <= 1'b0;
      if (e_carry) begin
        sat_hit <= 1'b1;
      end else begin
        e <= e_sum[COUNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter
// -------------
// Bench for freq_meter with a 100-cycle window and a 4-bit count so that
// saturation is reachable. A reference model turns the sampled input history
// into expected window results that a monitor compares against the outputs.

module tb_freq_meter;

  localparam int GATE = 100;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          sig = 1'b0;
  logic [CW-1:0] count;
  logic          valid;
  logic          ovf;

  typedef struct {
    int count;
    bit ovf;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  bit   hist[$];
  int   cyc = 0;
  int   pos = 0;
  int   acc = 0;
  int   last_count = 0;
  bit   last_ovf = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Signal generator controls: 0 manual, 1 periodic, 2 random
  int   mode = 0;
  int   per = 10;
  int   hi = 5;
  bit   man_sig = 1'b0;
  int   ph = 0;
  int   left = 2;
  bit   rs = 1'b0;

  always #5 clk = ~clk;

  freq_meter #(
    .GATE_CYCLES(GATE),
    .COUNT_W(CW)
  ) dut (
    .i_clock(clk),
    .i_reset_n(rst_n),
    .i_enable(en),
    .i_sig(sig),
    .o_count(count),
    .o_valid(valid),
    .o_overflow(ovf)
  );

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic run_windows(input int n);
    repeat (n * GATE) @(negedge clk);
  endtask

  task automatic wait_pos(input int target);
    int budget;
    budget = 3 * GATE;
    while (pos != target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_output("wait_window_position", pos, target);
  endtask

  // Drives i_sig shortly after each falling edge according to the mode.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      case (mode)
        1: begin
          sig = (ph < hi);
          ph  = (ph + 1) % per;
        end
        2: begin
          if (left == 0) begin
            rs   = ~rs;
            left = $urandom_range(2, 7);
          end
          left--;
          sig = rs;
        end
        default: sig = man_sig;
      endcase
    end
  end

  // Reference model: a window is GATE consecutive enabled edges; an edge
  // counts a rise when the input sampled two edges earlier was high and the
  // one before that was low. Results clip at CMAX with overflow flagged.
  always @(posedge clk) begin : model
    bit   r;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      hist.delete();
      repeat (3) hist.push_back(1'b0);
      pos = 0;
      acc = 0;
      last_count = 0;
      last_ovf = 1'b0;
      exp_q.delete();
    end else begin
      hist.push_back(sig);
      r = hist[1] & ~hist[0];
      void'(hist.pop_front());
      if (!en) begin
        pos = 0;
        acc = 0;
      end else begin
        acc += int'(r);
        pos++;
        if (pos == GATE) begin
          e.count = (acc > CMAX) ? CMAX : acc;
          e.ovf   = (acc > CMAX);
          e.cyc   = cyc;
          exp_q.push_back(e);
          last_count = e.count;
          last_ovf   = e.ovf;
          pos = 0;
          acc = 0;
        end
      end
    end
  end

  // Monitor: checks the strobe timing every cycle, the published values on
  // each strobe, and that the outputs hold in between.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   due;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check_output("valid_missing", 0, 1);
      void'(exp_q.pop_front());
    end
    due = (exp_q.size() > 0 && exp_q[0].cyc == cyc);
    check_output("valid", int'(valid), int'(due));
    if (due) begin
      e = exp_q.pop_front();
      check_output("count", int'(count), e.count);
      check_output("overflow", int'(ovf), int'(e.ovf));
    end else begin
      check_output("count_hold", int'(count), last_count);
      check_output("overflow_hold", int'(ovf), int'(last_ovf));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    mode = 0;
    man_sig = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_output("reset_count", int'(count), 0);
    check_output("reset_valid", int'(valid), 0);
    check_output("reset_overflow", int'(ovf), 0);

    // Input already high at reset release: one rise in the first window only
    man_sig = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    run_windows(3);

    // Steady period of 10 clocks
    per = 10; hi = 5; ph = 0; mode = 1;
    run_windows(4);

    // Saturation with period 4, then recovery with period 20
    per = 4; hi = 2; ph = 0;
    run_windows(3);
    per = 20; hi = 10; ph = 0;
    run_windows(3);

    // Constant low input
    mode = 0; man_sig = 1'b0;
    run_windows(2);

    // Random high/low times of at least two clocks
    mode = 2;
    run_windows(5);

    // Single rise landing in the terminal cycle
    mode = 0; man_sig = 1'b0;
    run_windows(1);
    wait_pos(97);
    man_sig = 1'b1;
    repeat (10) @(negedge clk);
    man_sig = 1'b0;
    run_windows(2);

    // Enable dropped at g = 50 for 30 cycles
    per = 10; hi = 5; ph = 0; mode = 1;
    run_windows(2);
    wait_pos(50);
    en = 1'b0;
    repeat (30) @(negedge clk);
    en = 1'b1;
    run_windows(3);

    // Asynchronous reset between clock edges, mid-window
    wait_pos(40);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_count", int'(count), 0);
    check_output("async_reset_valid", int'(valid), 0);
    check_output("async_reset_overflow", int'(ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_windows(3);

    repeat (5) @(negedge clk);
    check_output("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
